axi_lite_bram_responder: RTL

- Native AXI4-Lite responder that turns JTAG-bridge (or other initiator) transactions into single-port BRAM accesses on the instruction-memory programming port.
- Replaces the vendor AXI-to-BRAM controller IP and adds working readback of instruction memory.
- Sits in the clk_div4 domain between the AXI4-Lite initiator and the memory port of the frost instance.

---
 rtl/axi_lite_bram_responder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_bram_responder.sv
// AXI4-Lite responder driving the single-port instruction-memory BRAM programming port.
// Independent write and read engines share the port through a round-robin arbiter.
module axi_lite_bram_responder #(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int BRAM_ADDR_WIDTH = 16,
   parameter int READ_LATENCY    = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [AXI_ADDR_WIDTH-1:0]  i_s_axi_awaddr,
   input  logic [2:0]                 i_s_axi_awprot,
   input  logic                       i_s_axi_awvalid,
   output logic                       o_s_axi_awready,
   input  logic [31:0]                i_s_axi_wdata,
   input  logic [3:0]                 i_s_axi_wstrb,
   input  logic                       i_s_axi_wvalid,
   output logic                       o_s_axi_wready,
   output logic [1:0]                 o_s_axi_bresp,
   output logic                       o_s_axi_bvalid,
   input  logic                       i_s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]  i_s_axi_araddr,
   input  logic [2:0]                 i_s_axi_arprot,
   input  logic                       i_s_axi_arvalid,
   output logic                       o_s_axi_arready,
   output logic [31:0]                o_s_axi_rdata,
   output logic [1:0]                 o_s_axi_rresp,
   output logic                       o_s_axi_rvalid,
   input  logic                       i_s_axi_rready,
   output logic                       o_bram_en,
   output logic [3:0]                 o_bram_we,
   output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
   output logic [31:0]                o_bram_wrdata,
   input  logic [31:0]                i_bram_rddata
);

   localparam int         WORD_AW     = BRAM_ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] LAT_LAST    = 2'(READ_LATENCY - 1);

   typedef enum logic [1:0] {W_COLLECT, W_ISSUE, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_e;

   wr_state_e          wr_state_q, wr_state_d;
   rd_state_e          rd_state_q, rd_state_d;
   logic               live_q;
   logic               aw_held_q, aw_held_d;
   logic               aw_oor_q, aw_oor_d;
   logic [WORD_AW-1:0] aw_addr_q, aw_addr_d;
   logic               w_held_q, w_held_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic [1:0]         bresp_q, bresp_d;
   logic               ar_oor_q, ar_oor_d;
   logic [WORD_AW-1:0] ar_addr_q, ar_addr_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [1:0]         rresp_q, rresp_d;
   logic [1:0]         lat_cnt_q, lat_cnt_d;
   logic               prio_q, prio_d;   // 1: read wins the next contested cycle

   logic aw_hs, w_hs, ar_hs;
   logic aw_oor_in, ar_oor_in;
   logic w_req, r_req, w_grant, r_grant;
   logic unused_bits;

   assign unused_bits = ^{i_s_axi_awprot, i_s_axi_arprot,
                          i_s_axi_awaddr[1:0], i_s_axi_araddr[1:0]};

   assign aw_oor_in = (i_s_axi_awaddr >> BRAM_ADDR_WIDTH) != '0;
   assign ar_oor_in = (i_s_axi_araddr >> BRAM_ADDR_WIDTH) != '0;

   assign o_s_axi_awready = live_q && (wr_state_q == W_COLLECT) && !aw_held_q;
   assign o_s_axi_wready  = live_q && (wr_state_q == W_COLLECT) && !w_held_q;
   assign o_s_axi_arready = live_q && (rd_state_q == R_IDLE);
   assign o_s_axi_bvalid  = (wr_state_q == W_RESP);
   assign o_s_axi_bresp   = bresp_q;
   assign o_s_axi_rvalid  = (rd_state_q == R_RESP);
   assign o_s_axi_rdata   = rdata_q;
   assign o_s_axi_rresp   = rresp_q;

   assign aw_hs = o_s_axi_awready && i_s_axi_awvalid;
   assign w_hs  = o_s_axi_wready && i_s_axi_wvalid;
   assign ar_hs = o_s_axi_arready && i_s_axi_arvalid;

   // Out-of-range accesses never request the port.
   assign w_req   = (wr_state_q == W_ISSUE) && !aw_oor_q;
   assign r_req   = (rd_state_q == R_ISSUE) && !ar_oor_q;
   assign w_grant = w_req && (!r_req || !prio_q);
   assign r_grant = r_req && (!w_req || prio_q);
   assign prio_d  = (w_req && r_req) ? !prio_q : prio_q;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      o_bram_en     = 1'b0;
      o_bram_we     = 4'h0;
      o_bram_addr   = '0;
      o_bram_wrdata = 32'h0;
      if (w_grant) begin
         o_bram_en     = 1'b1;
         o_bram_we     = wstrb_q;
         o_bram_addr   = {aw_addr_q, 2'b00};
         o_bram_wrdata = wdata_q;
      end else if (r_grant) begin
         o_bram_en   = 1'b1;
         o_bram_addr = {ar_addr_q, 2'b00};
      end
   end

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      aw_oor_d   = aw_oor_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      case (wr_state_q)
         W_COLLECT: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               aw_oor_d  = aw_oor_in;
               aw_addr_d = i_s_axi_awaddr[BRAM_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = i_s_axi_wdata;
               wstrb_d  = i_s_axi_wstrb;
            end
            if (aw_held_d && w_held_d) wr_state_d = W_ISSUE;
         end
         W_ISSUE: begin
            if (aw_oor_q) begin
               bresp_d    = RESP_SLVERR;
               wr_state_d = W_RESP;
            end else if (w_grant) begin
               bresp_d    = RESP_OKAY;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (i_s_axi_bready) begin
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = W_COLLECT;
            end
         end
         default: wr_state_d = W_COLLECT;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      ar_oor_d   = ar_oor_q;
      ar_addr_d  = ar_addr_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      lat_cnt_d  = lat_cnt_q;
      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               ar_oor_d   = ar_oor_in;
               ar_addr_d  = i_s_axi_araddr[BRAM_ADDR_WIDTH-1:2];
               rd_state_d = R_ISSUE;
            end
         end
         R_ISSUE: begin
            if (ar_oor_q) begin
               rdata_d    = 32'h0;
               rresp_d    = RESP_SLVERR;
               rd_state_d = R_RESP;
            end else if (r_grant) begin
               lat_cnt_d  = 2'd0;
               rd_state_d = R_WAIT;
            end
         end
         R_WAIT: begin
            // The last wait cycle is exactly READ_LATENCY cycles after the enable.
            if (lat_cnt_q == LAT_LAST) begin
               rdata_d    = i_bram_rddata;
               rresp_d    = RESP_OKAY;
               rd_state_d = R_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         R_RESP: begin
            if (i_s_axi_rready) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         live_q     <= 1'b0;
         wr_state_q <= W_COLLECT;
         rd_state_q <= R_IDLE;
         aw_held_q  <= 1'b0;
         aw_oor_q   <= 1'b0;
         aw_addr_q  <= '0;
         w_held_q   <= 1'b0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         bresp_q    <= RESP_OKAY;
         ar_oor_q   <= 1'b0;
         ar_addr_q  <= '0;
         rdata_q    <= 32'h0;
         rresp_q    <= RESP_OKAY;
         lat_cnt_q  <= 2'd0;
         prio_q     <= 1'b0;
      end else begin
         live_q     <= 1'b1;
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         aw_held_q  <= aw_held_d;
         aw_oor_q   <= aw_oor_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         ar_oor_q   <= ar_oor_d;
         ar_addr_q  <= ar_addr_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         lat_cnt_q  <= lat_cnt_d;
         prio_q     <= prio_d;
      end
   end

endmodule
